// File: rtl/sw_csr_pkg.sv
// Shared constants and decode types for the switch software CSR block.
// Address map, CTRL encodings and STATUS field positions live here.
package sw_csr_pkg;

   localparam int ADDR_CTRL       = 0;
   localparam int ADDR_STATUS     = 1;
   localparam int ADDR_PORT_BASE  = 2;
   localparam int CTRL_EXPERIMENT = 2;
   localparam int STATUS_OVF_LSB  = 8;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_CTRL,
      SEL_STATUS,
      SEL_PORT
   } reg_sel_e;

endpackage

// File: rtl/meta_fifo.sv
// Single-clock show-ahead FIFO for one port's egress metadata.
// A push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
module meta_fifo
   import sw_csr_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full,
   output logic              ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic              do_pop;
   logic              do_push;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + 1'b1;
      end else if (do_pop && !do_push) begin
         count_next = count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ready  <= 1'b0;
      end else begin
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         count <= count_next;
         ready <= (count_next != CNT_W'(DEPTH));
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sw_port_csr.sv
// Avalon-MM CSR block: CTRL register, per-port command strobes and
// per-port egress metadata FIFOs with sticky overflow flags.
module sw_port_csr
   import sw_csr_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              chipselect,
   input  logic                              write,
   input  logic                              read,
   input  logic [ADDR_W-1:0]                 address,
   input  logic [DATA_W-1:0]                 writedata,
   output logic [DATA_W-1:0]                 readdata,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0]  meta_in,
   input  logic [NUM_PORTS-1:0]              meta_in_valid,
   output logic [NUM_PORTS-1:0]              meta_ready,
   output logic [DATA_W-1:0]                 cmd_out,
   output logic [NUM_PORTS-1:0]              cmd_out_en,
   output logic [DATA_W-1:0]                 ctrl,
   output logic                              experimenting
);

   reg_sel_e             sel;
   logic [NUM_PORTS-1:0] port_hit;
   logic                 wr_en;
   logic                 rd_en;
   logic [NUM_PORTS-1:0] pop;
   logic [NUM_PORTS-1:0] empty;
   logic [NUM_PORTS-1:0] full;
   logic [DATA_W-1:0]    dout [NUM_PORTS];
   logic [NUM_PORTS-1:0] ovf;
   logic [NUM_PORTS-1:0] ovf_set;
   logic [NUM_PORTS-1:0] ovf_clr;
   logic [DATA_W-1:0]    status;
   logic [DATA_W-1:0]    rd_mux;

   assign wr_en = chipselect && write;
   assign rd_en = chipselect && read;
   assign pop   = rd_en ? port_hit : '0;

   always_comb begin
      sel      = SEL_NONE;
      port_hit = '0;
      if (address == ADDR_W'(ADDR_CTRL)) begin
         sel = SEL_CTRL;
      end else if (address == ADDR_W'(ADDR_STATUS)) begin
         sel = SEL_STATUS;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (address == ADDR_W'(ADDR_PORT_BASE + i)) begin
               sel         = SEL_PORT;
               port_hit[i] = 1'b1;
            end
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_PORTS; g++) begin : g_fifo
         meta_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
         ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (meta_in_valid[g]),
            .pop   (pop[g]),
            .din   (meta_in[g]),
            .dout  (dout[g]),
            .empty (empty[g]),
            .full  (full[g]),
            .ready (meta_ready[g])
         );
      end
   endgenerate

   // A dropped push sets the flag even if software clears it in the same cycle.
   assign ovf_set = meta_in_valid & full & ~pop;
   assign ovf_clr = (wr_en && sel == SEL_STATUS) ? writedata[STATUS_OVF_LSB +: NUM_PORTS] : '0;

   always_comb begin
      status                              = '0;
      status[NUM_PORTS-1:0]               = ~empty;
      status[STATUS_OVF_LSB +: NUM_PORTS] = ovf;
   end

   always_comb begin
      rd_mux = '0;
      case (sel)
         SEL_CTRL:   rd_mux = ctrl;
         SEL_STATUS: rd_mux = status;
         SEL_PORT: begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               if (port_hit[i] && !empty[i]) rd_mux = dout[i];
            end
         end
         default:    rd_mux = '0;
      endcase
   end

   assign experimenting = (ctrl == DATA_W'(CTRL_EXPERIMENT));

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl       <= '0;
         readdata   <= '0;
         cmd_out    <= '0;
         cmd_out_en <= '0;
         ovf        <= '0;
      end else begin
         ovf        <= (ovf & ~ovf_clr) | ovf_set;
         cmd_out_en <= wr_en ? port_hit : '0;
         if (wr_en && sel == SEL_CTRL) ctrl <= writedata;
         if (wr_en && sel == SEL_PORT) cmd_out <= writedata;
         if (rd_en) readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_sw_port_csr.sv
// Self-checking bench for sw_port_csr: a behavioural model predicts every read,
// expected read data is queued at issue time and compared once the DUT returns it.
module tb_sw_port_csr;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int DEPTH = 8;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                chipselect = 1'b0;
   logic                write = 1'b0;
   logic                read = 1'b0;
   logic [3:0]          address = '0;
   logic [DW-1:0]       writedata = '0;
   logic [DW-1:0]       readdata;
   logic [NP-1:0][DW-1:0] meta_in = '0;
   logic [NP-1:0]       meta_in_valid = '0;
   logic [NP-1:0]       meta_ready;
   logic [DW-1:0]       cmd_out;
   logic [NP-1:0]       cmd_out_en;
   logic [DW-1:0]       ctrl;
   logic                experimenting;

   sw_port_csr #(
      .NUM_PORTS  (NP),
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH),
      .ADDR_W     (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .chipselect    (chipselect),
      .write         (write),
      .read          (read),
      .address       (address),
      .writedata     (writedata),
      .readdata      (readdata),
      .meta_in       (meta_in),
      .meta_in_valid (meta_in_valid),
      .meta_ready    (meta_ready),
      .cmd_out       (cmd_out),
      .cmd_out_en    (cmd_out_en),
      .ctrl          (ctrl),
      .experimenting (experimenting)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   logic [DW-1:0] mq [NP][$];
   logic [DW-1:0] sb [$];
   logic [NP-1:0] ovf_m;
   logic [DW-1:0] ctrl_m;
   logic [DW-1:0] cmd_m;
   logic [DW-1:0] rd_exp;
   logic [NP-1:0] en_exp;

   function automatic logic [NP-1:0] model_ready();
      logic [NP-1:0] r;
      for (int i = 0; i < NP; i++) r[i] = (mq[i].size() != DEPTH);
      return r;
   endfunction

   function automatic logic [DW-1:0] model_status();
      logic [DW-1:0] s;
      s = '0;
      for (int i = 0; i < NP; i++) begin
         s[i]     = (mq[i].size() != 0);
         s[8 + i] = ovf_m[i];
      end
      return s;
   endfunction

   // One bus/meta cycle: update model, queue the read expectation, clock, retire it.
   task automatic step(input bit rd_i, input bit wr_i, input logic [3:0] a,
                       input logic [DW-1:0] wd, input logic [NP-1:0] pv, input logic [DW-1:0] pd);
      logic [DW-1:0] e;
      int p;
      bit popped;
      p = int'(a) - 2;
      e = '0;
      popped = 1'b0;
      en_exp = '0;
      if (rd_i) begin
         if (a == 4'd0) e = ctrl_m;
         else if (a == 4'd1) e = model_status();
         else if (p >= 0 && p < NP && mq[p].size() != 0) begin
            e = mq[p].pop_front();
            popped = 1'b1;
         end
         sb.push_back(e);
      end
      if (wr_i) begin
         if (a == 4'd0) ctrl_m = wd;
         else if (a == 4'd1) ovf_m = ovf_m & ~wd[8 +: NP];
         else if (p >= 0 && p < NP) begin
            cmd_m = wd;
            en_exp[p] = 1'b1;
         end
      end
      for (int i = 0; i < NP; i++) begin
         if (pv[i]) begin
            if (mq[i].size() < DEPTH) mq[i].push_back(pd);
            else ovf_m[i] = 1'b1;
         end
         meta_in[i] = pd;
      end
      chipselect = rd_i | wr_i;
      read = rd_i;
      write = wr_i;
      address = a;
      writedata = wd;
      meta_in_valid = pv;
      @(negedge clk);
      chipselect = 1'b0;
      read = 1'b0;
      write = 1'b0;
      meta_in_valid = '0;
      if (rd_i) begin
         if (sb.size() != 0) rd_exp = sb.pop_front();
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'd0, '0, '0, '0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < NP; i++) mq[i].delete();
      sb.delete();
      ovf_m = '0;
      ctrl_m = '0;
      cmd_m = '0;
      rd_exp = '0;
      en_exp = '0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (ctrl !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", ctrl); end
      n_checks++; if (readdata !== '0) begin n_fail++; $display("FAIL reset_readdata: got %h want 0", readdata); end
      n_checks++; if (cmd_out !== '0) begin n_fail++; $display("FAIL reset_cmd_out: got %h want 0", cmd_out); end
      n_checks++; if (cmd_out_en !== '0) begin n_fail++; $display("FAIL reset_cmd_out_en: got %b want 0", cmd_out_en); end
      n_checks++; if (experimenting !== 1'b0) begin n_fail++; $display("FAIL reset_experimenting: got %b want 0", experimenting); end
      reset = 1'b0;
      idle();
      n_checks++; if (meta_ready !== 4'hF) begin n_fail++; $display("FAIL reset_meta_ready: got %b want 1111", meta_ready); end
   endtask

   task automatic test_ctrl();
      step(1'b0, 1'b1, 4'd0, 32'h2, '0, '0);
      n_checks++; if (experimenting !== 1'b1) begin n_fail++; $display("FAIL ctrl_experimenting: got %b want 1", experimenting); end
      n_checks++; if (ctrl !== ctrl_m) begin n_fail++; $display("FAIL ctrl_value: got %h want %h", ctrl, ctrl_m); end
      step(1'b1, 1'b0, 4'd0, '0, '0, '0);
      n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL ctrl_read: got %h want %h", readdata, rd_exp); end
      step(1'b0, 1'b1, 4'd15, 32'hFFFF_FFFF, '0, '0);
      step(1'b1, 1'b0, 4'd15, '0, '0, '0);
      n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL unmapped_read: got %h want %h", readdata, rd_exp); end
      n_checks++; if (ctrl !== ctrl_m) begin n_fail++; $display("FAIL unmapped_write_ctrl: got %h want %h", ctrl, ctrl_m); end
   endtask

   task automatic test_cmd();
      step(1'b0, 1'b1, 4'd4, 32'hDEAD_BEEF, '0, '0);
      n_checks++; if (cmd_out !== cmd_m) begin n_fail++; $display("FAIL cmd_out: got %h want %h", cmd_out, cmd_m); end
      n_checks++; if (cmd_out_en !== en_exp) begin n_fail++; $display("FAIL cmd_out_en: got %b want %b", cmd_out_en, en_exp); end
      idle();
      n_checks++; if (cmd_out_en !== en_exp) begin n_fail++; $display("FAIL cmd_out_en_drop: got %b want %b", cmd_out_en, en_exp); end
      n_checks++; if (cmd_out !== cmd_m) begin n_fail++; $display("FAIL cmd_out_hold: got %h want %h", cmd_out, cmd_m); end
   endtask

   task automatic test_fifo();
      step(1'b0, 1'b0, 4'd0, '0, 4'b0010, 32'h11);
      step(1'b0, 1'b0, 4'd0, '0, 4'b0010, 32'h22);
      step(1'b1, 1'b0, 4'd1, '0, '0, '0);
      n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL fifo_status_nonempty: got %h want %h", readdata, rd_exp); end
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 4'd3, '0, '0, '0);
         n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL fifo_read%0d: got %h want %h", k, readdata, rd_exp); end
      end
      step(1'b1, 1'b0, 4'd1, '0, '0, '0);
      n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL fifo_status_empty: got %h want %h", readdata, rd_exp); end
   endtask

   task automatic test_overflow();
      for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 4'd0, '0, 4'b0001, 32'h100 + k);
      n_checks++; if (meta_ready !== model_ready()) begin n_fail++; $display("FAIL ovf_meta_ready: got %b want %b", meta_ready, model_ready()); end
      step(1'b1, 1'b0, 4'd1, '0, '0, '0);
      n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL ovf_status_set: got %h want %h", readdata, rd_exp); end
      step(1'b0, 1'b1, 4'd1, 32'h100, '0, '0);
      step(1'b1, 1'b0, 4'd1, '0, '0, '0);
      n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL ovf_status_clear: got %h want %h", readdata, rd_exp); end
      // overflow and W1C on the same bit in one cycle
      step(1'b0, 1'b1, 4'd1, 32'h100, 4'b0001, 32'hBAD);
      step(1'b1, 1'b0, 4'd1, '0, '0, '0);
      n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL ovf_set_wins: got %h want %h", readdata, rd_exp); end
      step(1'b0, 1'b1, 4'd1, 32'h100, '0, '0);
      for (int k = 0; k < DEPTH; k++) begin
         step(1'b1, 1'b0, 4'd2, '0, '0, '0);
         n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL ovf_drain%0d: got %h want %h", k, readdata, rd_exp); end
      end
      n_checks++; if (meta_ready !== model_ready()) begin n_fail++; $display("FAIL ovf_ready_after_drain: got %b want %b", meta_ready, model_ready()); end
   endtask

   task automatic test_full_push_pop();
      for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b0, 4'd0, '0, 4'b1000, 32'h300 + k);
      n_checks++; if (meta_ready[3] !== 1'b0) begin n_fail++; $display("FAIL fpp_full_ready: got %b want 0", meta_ready[3]); end
      step(1'b1, 1'b0, 4'd5, '0, 4'b1000, 32'h3FF);
      n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL fpp_head: got %h want %h", readdata, rd_exp); end
      n_checks++; if (meta_ready !== model_ready()) begin n_fail++; $display("FAIL fpp_ready: got %b want %b", meta_ready, model_ready()); end
      step(1'b1, 1'b0, 4'd1, '0, '0, '0);
      n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL fpp_status: got %h want %h", readdata, rd_exp); end
      for (int k = 0; k < DEPTH; k++) begin
         step(1'b1, 1'b0, 4'd5, '0, '0, '0);
         n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL fpp_order%0d: got %h want %h", k, readdata, rd_exp); end
      end
   endtask

   task automatic test_empty_push_read();
      step(1'b1, 1'b0, 4'd4, '0, 4'b0100, 32'hABC);
      n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL epr_first: got %h want %h", readdata, rd_exp); end
      step(1'b1, 1'b0, 4'd4, '0, '0, '0);
      n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL epr_retained: got %h want %h", readdata, rd_exp); end
   endtask

   task automatic test_back_to_back();
      step(1'b1, 1'b1, 4'd0, 32'h5, '0, '0);
      n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL b2b_rw_read: got %h want %h", readdata, rd_exp); end
      n_checks++; if (ctrl !== ctrl_m) begin n_fail++; $display("FAIL b2b_rw_ctrl: got %h want %h", ctrl, ctrl_m); end
      n_checks++; if (experimenting !== 1'b0) begin n_fail++; $display("FAIL b2b_rw_exp: got %b want 0", experimenting); end
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'd0, '0, 4'b1111, $urandom);
      for (int k = 0; k < 3 * NP; k++) begin
         step(1'b1, 1'b0, 4'(2 + (k % NP)), '0, '0, '0);
         n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL b2b_read%0d: got %h want %h", k, readdata, rd_exp); end
      end
   endtask

   task automatic test_reset_mid();
      step(1'b0, 1'b0, 4'd0, '0, 4'b0011, 32'h77);
      step(1'b0, 1'b0, 4'd0, '0, 4'b0001, 32'h78);
      step(1'b0, 1'b1, 4'd2, 32'h1234, '0, '0);
      do_reset();
      n_checks++; if (cmd_out_en !== '0) begin n_fail++; $display("FAIL rmid_cmd_out_en: got %b want 0", cmd_out_en); end
      n_checks++; if (cmd_out !== '0) begin n_fail++; $display("FAIL rmid_cmd_out: got %h want 0", cmd_out); end
      reset = 1'b0;
      idle();
      n_checks++; if (meta_ready !== 4'hF) begin n_fail++; $display("FAIL rmid_meta_ready: got %b want 1111", meta_ready); end
      step(1'b1, 1'b0, 4'd1, '0, '0, '0);
      n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL rmid_status: got %h want %h", readdata, rd_exp); end
      step(1'b1, 1'b0, 4'd2, '0, '0, '0);
      n_checks++; if (readdata !== rd_exp) begin n_fail++; $display("FAIL rmid_port0: got %h want %h", readdata, rd_exp); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_ctrl();
      test_cmd();
      test_fifo();
      test_overflow();
      test_full_push_pop();
      test_empty_push_read();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
